// File: rtl/lfsr_gen_if.sv
// rtl/lfsr_gen_if.sv - control and status bundle for lfsr_gen
interface lfsr_gen_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             mode;
  logic             ext_en;
  logic             d;
  logic             q;
  logic [WIDTH-1:0] state;
  logic             lockup;
  logic             period_done;
  logic [CNT_W-1:0] period_len;

  // Driver side: issues step/load/mode controls and observes the register.
  modport master (
    output en, load, seed_in, mode, ext_en, d,
    input  q, state, lockup, period_done, period_len
  );

  // Generator side.
  modport slave (
    input  en, load, seed_in, mode, ext_en, d,
    output q, state, lockup, period_done, period_len
  );
endinterface

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci/Galois LFSR with injection, recovery and period measurement
module lfsr_gen #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'h0001),
  parameter int               CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  lfsr_gen_if.slave  bus
);

  // Galois xor mask: taps shifted up one place, with the constant term in bit 0.
  localparam logic [WIDTH-1:0] GAL_MASK = {TAPS[WIDTH-2:0], 1'b1};

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_ref;
  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] r_period_len;
  logic             r_mode_q;
  logic             r_mode_vld;
  logic             r_lockup;
  logic             r_period_done;

  logic             w_inj;
  logic             w_mode_q;
  logic             w_fib_fb;
  logic             w_gal_m;
  logic [WIDTH-1:0] w_fib_next;
  logic [WIDTH-1:0] w_gal_next;
  logic [WIDTH-1:0] w_step_next;
  logic [WIDTH-1:0] w_seed_eff;
  logic [CNT_W-1:0] w_cnt_inc;

  logic [WIDTH-1:0] w_state_d;
  logic [WIDTH-1:0] w_ref_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W-1:0] w_plen_d;
  logic             w_lockup_d;
  logic             w_pdone_d;

  // Until the first clock after reset the remembered mode is whatever is
  // being driven, so a mode held through reset never looks like a switch.
  // This keeps every reset value a constant.
  assign w_mode_q = r_mode_vld ? r_mode_q : bus.mode;

  assign w_inj      = bus.ext_en & bus.d;
  assign w_fib_fb   = (^(r_state & TAPS)) ^ w_inj;
  assign w_fib_next = {r_state[WIDTH-2:0], w_fib_fb};
  assign w_gal_m    = r_state[WIDTH-1] ^ w_inj;
  assign w_gal_next = {r_state[WIDTH-2:0], 1'b0} ^ ({WIDTH{w_gal_m}} & GAL_MASK);
  assign w_step_next = w_mode_q ? w_gal_next : w_fib_next;

  // A zero seed would park the register in lock-up, so it is never stored.
  assign w_seed_eff = (bus.seed_in == '0) ? SEED : bus.seed_in;
  assign w_cnt_inc  = r_step_cnt + CNT_W'(1);

  // Next-state selection: load, mode switch, lock-up recovery, step, hold.
  always_comb begin
    w_state_d  = r_state;
    w_ref_d    = r_ref;
    w_cnt_d    = r_step_cnt;
    w_plen_d   = r_period_len;
    w_lockup_d = 1'b0;
    w_pdone_d  = 1'b0;
    if (bus.load) begin
      w_state_d = w_seed_eff;
      w_ref_d   = w_seed_eff;
      w_cnt_d   = '0;
    end else if (bus.mode != w_mode_q) begin
      // Topology change: restart the period measurement from here.
      w_ref_d = r_state;
      w_cnt_d = '0;
    end else if (bus.en && (r_state == '0) && !w_inj) begin
      w_state_d  = SEED;
      w_ref_d    = SEED;
      w_cnt_d    = '0;
      w_lockup_d = 1'b1;
    end else if (bus.en) begin
      w_state_d = w_step_next;
      if (w_step_next == r_ref) begin
        w_pdone_d = 1'b1;
        w_plen_d  = w_cnt_inc;
        w_cnt_d   = '0;
      end else begin
        w_cnt_d = w_cnt_inc;
      end
    end
  end

  // Register update; reset also drops any pulse in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= SEED;
      r_ref         <= SEED;
      r_step_cnt    <= '0;
      r_period_len  <= '0;
      r_mode_q      <= 1'b0;
      r_mode_vld    <= 1'b0;
      r_lockup      <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_ref         <= w_ref_d;
      r_step_cnt    <= w_cnt_d;
      r_period_len  <= w_plen_d;
      r_mode_q      <= bus.mode;
      r_mode_vld    <= 1'b1;
      r_lockup      <= w_lockup_d;
      r_period_done <= w_pdone_d;
    end
  end

  assign bus.q           = r_state[WIDTH-1];
  assign bus.state       = r_state;
  assign bus.lockup      = r_lockup;
  assign bus.period_done = r_period_done;
  assign bus.period_len  = r_period_len;

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised LFSR generator for the DA sizing and regression benches; successor to the fixed 10-stage XNOR shift chain.
- Width, polynomial and seed are parameters; Fibonacci or Galois topology is selected at run time.
- Adds clock enable, seed load, serial data injection, lock-up recovery, and period measurement.
- Instances chain serially: q of one feeds d of the next, as the existing cascades do.

Parameters:
- WIDTH, 16, number of state bits, minimum 2.
- TAPS, 16'hB400, feedback mask; bit i set means state[i] is tapped. Bit WIDTH-1 must be set; default is x^16+x^14+x^13+x^11+1.
- SEED, 16'h0001, reset and recovery state; must be nonzero.
- CNT_W, 32, width of the step counter and period register.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance the register one step this cycle.
- load  in  1  load seed_in this cycle; priority over en.
- seed_in  in  WIDTH  value for load.
- mode  in  1  0 = Fibonacci, 1 = Galois.
- ext_en  in  1  enable serial injection of d.
- d  in  1  serial injection bit.
- q  out  1  serial output, equal to state[WIDTH-1] (combinational from the register).
- state  out  WIDTH  current register contents.
- lockup  out  1  one-cycle pulse when the all-zero state is recovered.
- period_done  out  1  one-cycle pulse when a step returns state to ref.
- period_len  out  CNT_W  step count captured at the last period_done.

Behaviour:
- Reset (async assert; release synchronous to clk): state=SEED, ref=SEED, mode_q=mode, step_cnt=0, period_len=0, lockup=0, period_done=0, so q=SEED[WIDTH-1].
- Internal registers: state, ref (comparison point), step_cnt, mode_q (last-cycle mode).
- Injection term: inj = ext_en & d.
- Fibonacci step: fb = ^(state & TAPS) ^ inj; next = {state[WIDTH-2:0], fb}.
- Galois step: m = state[WIDTH-1] ^ inj; next = {state[WIDTH-2:0],1'b0} ^ ({WIDTH{m}} & {TAPS[WIDTH-2:0],1'b1}).
- Per-cycle priority, highest first:
  1. load: state=(seed_in==0 ? SEED : seed_in); ref=same value; step_cnt=0; no step; no pulses.
  2. mode != mode_q: state held; ref=state; step_cnt=0; mode_q=mode. The new topology applies from the next step; en is ignored this cycle.
  3. en && state==0 && !inj (lock-up): state=SEED; ref=SEED; step_cnt=0; lockup=1 for one cycle.
  4. en: state=next; cnt=step_cnt+1.
     - If next==ref: period_done=1 for one cycle, period_len=cnt, step_cnt=0.
     - Otherwise: step_cnt=cnt.
  5. Else: everything holds; pulses are 0.
- step_cnt wraps modulo 2^CNT_W without any flag.
- Latency: state and q reflect a step, load, or recovery on the same clock edge. There is no pipeline.
- All-zero state:
  - Reachable only via injection or a mid-operation load race. A zero seed_in is substituted, never stored.
  - With ext_en=1 and d=1 the zero state escapes normally, with no lockup pulse.
- Injection does not suppress the ref compare. period_done fires whenever state reaches ref, whatever path led there.
- Reset mid-operation aborts everything immediately. Any pulse in flight is cleared.
- With the default TAPS the period is 65535 in both modes.

Test Plan:
- Fibonacci sequence: WIDTH=4, TAPS=4'hC, SEED=1; reset, then en=1, mode=0, ext_en=0 -> state 1,2,4,9,3,6,D,... ; period_done on step 15 with period_len=15; q tracks state[3].
- Galois period: same parameters, mode=1 held from reset, en=1 -> period_done on step 15, period_len=15. Repeat at default parameters -> period_len=65535 in both modes.
- Load priority: load=1, en=1, seed_in=4'h5 -> state=5 with no step, step_cnt=0, no pulses. load with seed_in=0 -> state=SEED.
- Lock-up: reach state=0 via injection (WIDTH=4, Fibonacci, drive d to flush zeros), then en=1, ext_en=0 -> next state=1, lockup high exactly one cycle, step_cnt=0. Same zero state with ext_en=1, d=1 -> state=1, lockup=0.
- Mode switch mid-run: after 5 Fibonacci steps toggle mode -> state held one cycle, ref=current state. Then 15 Galois steps -> period_done with period_len=15.
- Async reset: assert reset between clock edges mid-run -> state=SEED, period_len=0 and pulses low immediately, without waiting for a clk edge. Release -> stepping resumes from SEED.
